// File: rtl/uart_rx_if.sv
// Consumer-side handshake bundle of the UART receiver: byte, valid/ack and status flags.
`timescale 1ns/1ps
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;

  modport master (input rx_ack, output rx_data, rx_valid, frame_err, overrun, parity_err);
  modport slave  (output rx_ack, input rx_data, rx_valid, frame_err, overrun, parity_err);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, majority-voted bits, valid/ack byte handshake.
// Optional even parity bit enabled with the UART_RX_PARITY_EN macro.
`timescale 1ns/1ps
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic      hwclk,
  input  logic      reset_n,
  input  logic      baud_clk,
  input  logic      rx,
  uart_rx_if.master bus
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [SW-1:0] S_EARLY = SW'(M - 1);
  localparam logic [SW-1:0] S_MID   = SW'(M);
  localparam logic [SW-1:0] S_DEC   = SW'(M + 1);
  localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] N_BITS  = BW'(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

`ifdef UART_RX_PARITY_EN
  function automatic logic even_parity_fail(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  state_t               state_r, state_s;
  logic [1:0]           rx_sync_r, baud_sync_r;
  logic                 baud_prev_r;
  logic [SW-1:0]        s_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [1:0]           samp_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 armed_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r, ferr_r, ovr_r, perr_r;
  logic                 tick_s, rx_s, at_dec_s, at_wrap_s, maj_s;
  logic                 start_s, shift_en_s, done_s, perr_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_r, par_en_s;
`endif

  assign rx_s      = rx_sync_r[1];
  assign tick_s    = baud_sync_r[1] & ~baud_prev_r;
  assign at_dec_s  = tick_s & (s_r == S_DEC);
  assign at_wrap_s = tick_s & (s_r == S_LAST);
  assign maj_s     = maj3(samp_r[0], samp_r[1], rx_s);

  // Two-flop synchronizers for rx and baud_clk, plus baud edge history
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync_r   <= 2'b11;
      baud_sync_r <= 2'b11;
      baud_prev_r <= 1'b1;
    end else begin
      rx_sync_r   <= {rx_sync_r[0], rx};
      baud_sync_r <= {baud_sync_r[0], baud_clk};
      baud_prev_r <= baud_sync_r[1];
    end
  end

  // FSM state register
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; STOP returns to IDLE mid-bit so the next start edge is caught
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_s = ST_START;
        else         state_s = ST_IDLE;
      end
      ST_START: begin
        if (at_dec_s && maj_s) state_s = ST_IDLE;
        else if (at_wrap_s)    state_s = ST_DATA;
        else                   state_s = ST_START;
      end
      ST_DATA: begin
`ifdef UART_RX_PARITY_EN
        if (at_wrap_s && (bit_cnt_r == N_BITS)) state_s = ST_PARITY;
`else
        if (at_wrap_s && (bit_cnt_r == N_BITS)) state_s = ST_STOP;
`endif
        else                                    state_s = ST_DATA;
      end
      ST_PARITY: begin
        if (at_wrap_s) state_s = ST_STOP;
        else           state_s = ST_PARITY;
      end
      ST_STOP: begin
        if (at_dec_s) state_s = ST_IDLE;
        else          state_s = ST_STOP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM output decode; a start needs the line to have been seen high since any break
  always_comb begin
    start_s    = 1'b0;
    shift_en_s = 1'b0;
    done_s     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE:   start_s    = tick_s & ~rx_s & armed_r;
      ST_DATA:   shift_en_s = at_dec_s;
`ifdef UART_RX_PARITY_EN
      ST_PARITY: par_en_s   = at_dec_s;
`endif
      ST_STOP:   done_s     = at_dec_s;
      default:   start_s    = 1'b0;
    endcase
  end

  // Sample counter, majority samples, shift register and break re-arm flag
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      s_r       <= '0;
      bit_cnt_r <= '0;
      samp_r    <= 2'b00;
      shift_r   <= '0;
      armed_r   <= 1'b1;
    end else begin
      if (state_s == ST_IDLE)                s_r <= '0;
      else if (tick_s && state_r != ST_IDLE) s_r <= at_wrap_s ? '0 : s_r + SW'(1);
      if (tick_s && s_r == S_EARLY) samp_r[0] <= rx_s;
      if (tick_s && s_r == S_MID)   samp_r[1] <= rx_s;
      if (state_r != ST_DATA) bit_cnt_r <= '0;
      else if (shift_en_s)    bit_cnt_r <= bit_cnt_r + BW'(1);
      if (shift_en_s) shift_r <= {maj_s, shift_r[DATA_BITS-1:1]};
      if (rx_s)                 armed_r <= 1'b1;
      else if (done_s && !maj_s) armed_r <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Captured parity bit
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      par_bit_r <= 1'b0;
    end else if (par_en_s) begin
      par_bit_r <= maj_s;
    end
  end
  assign perr_s = even_parity_fail(shift_r, par_bit_r);
`else
  assign perr_s = 1'b0;
`endif

  // Consumer handshake: an ack in the completion cycle frees the slot for the new byte
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
      perr_r  <= 1'b0;
    end else if (done_s) begin
      if (!valid_r || bus.rx_ack) begin
        data_r  <= shift_r;
        valid_r <= 1'b1;
        ferr_r  <= ~maj_s;
        perr_r  <= perr_s;
      end else begin
        ovr_r   <= 1'b1;
      end
    end else if (bus.rx_ack) begin
      valid_r <= 1'b0;
    end
  end

  assign bus.rx_data    = data_r;
  assign bus.rx_valid   = valid_r;
  assign bus.frame_err  = ferr_r;
  assign bus.overrun    = ovr_r;
  assign bus.parity_err = perr_r;
endmodule
